// File: rtl/ball_pkg.sv
// Shared types and HID keycodes for the ball motion scheduler.
package ball_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  localparam logic [7:0] KC_UP    = 8'h1A;
  localparam logic [7:0] KC_DOWN  = 8'h16;
  localparam logic [7:0] KC_LEFT  = 8'h04;
  localparam logic [7:0] KC_RIGHT = 8'h07;
  localparam logic [7:0] KC_SPACE = 8'h2C;

  // Bit positions inside the present/prev key vectors.
  localparam int P_UP    = 3;
  localparam int P_DOWN  = 2;
  localparam int P_LEFT  = 1;
  localparam int P_RIGHT = 0;

endpackage

// File: rtl/key_scan.sv
// Combinational scan of the four HID slots into a direction-key vector and a SPACE flag.
module key_scan
  import ball_pkg::*;
(
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  output logic [3:0] present,
  output logic       space_present
);

  logic [7:0] slots [4];

  assign slots[0] = keycode0;
  assign slots[1] = keycode1;
  assign slots[2] = keycode2;
  assign slots[3] = keycode3;

  // OR across slots, so duplicates count once and unknown codes fall through.
  always_comb begin
    present       = '0;
    space_present = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present[P_UP]    = present[P_UP]    | (slots[i] == KC_UP);
      present[P_DOWN]  = present[P_DOWN]  | (slots[i] == KC_DOWN);
      present[P_LEFT]  = present[P_LEFT]  | (slots[i] == KC_LEFT);
      present[P_RIGHT] = present[P_RIGHT] | (slots[i] == KC_RIGHT);
      space_present    = space_present    | (slots[i] == KC_SPACE);
    end
  end

endmodule

// File: rtl/ball_motion_sched.sv
// Per-frame motion scheduler: key press -> direction, pause toggle, hold-to-accelerate step.
// Optional build macro NO_REVERSE_EN drops presses of the key opposite the current direction.
module ball_motion_sched
  import ball_pkg::*;
#(
  parameter logic [9:0] MAX_STEP    = 10'd4,
  parameter logic [7:0] RAMP_FRAMES = 8'd30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  output logic [9:0] step_x,
  output logic [9:0] step_y,
  output logic [2:0] dir,
  output logic       paused
);

  logic [3:0] present;
  logic       space_present;
  logic [3:0] new_press;
  logic [3:0] cand;

  dir_t       dir_q, dir_d;
  logic [3:0] prev_q, prev_d;
  logic       prev_space_q, prev_space_d;
  logic       paused_q, paused_d;
  logic [9:0] step_q, step_d;
  logic [7:0] hold_q, hold_d;
  logic [9:0] step_x_q, step_x_d;
  logic [9:0] step_y_q, step_y_d;
  logic [9:0] neg_step;

  key_scan u_key_scan (
    .keycode0      (keycode0),
    .keycode1      (keycode1),
    .keycode2      (keycode2),
    .keycode3      (keycode3),
    .present       (present),
    .space_present (space_present)
  );

  function automatic logic dir_present(input dir_t d, input logic [3:0] p);
    case (d)
      UP:      dir_present = p[P_UP];
      DOWN:    dir_present = p[P_DOWN];
      LEFT:    dir_present = p[P_LEFT];
      RIGHT:   dir_present = p[P_RIGHT];
      default: dir_present = 1'b0;
    endcase
  endfunction

`ifdef NO_REVERSE_EN
  function automatic logic [3:0] reverse_mask(input dir_t d);
    reverse_mask = '0;
    case (d)
      UP:      reverse_mask[P_DOWN]  = 1'b1;
      DOWN:    reverse_mask[P_UP]    = 1'b1;
      LEFT:    reverse_mask[P_RIGHT] = 1'b1;
      RIGHT:   reverse_mask[P_LEFT]  = 1'b1;
      default: reverse_mask = '0;
    endcase
  endfunction
`endif

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      dir_q        <= IDLE;
      prev_q       <= '0;
      prev_space_q <= 1'b0;
      paused_q     <= 1'b0;
      step_q       <= 10'd1;
      hold_q       <= '0;
      step_x_q     <= '0;
      step_y_q     <= '0;
    end else begin
      dir_q        <= dir_d;
      prev_q       <= prev_d;
      prev_space_q <= prev_space_d;
      paused_q     <= paused_d;
      step_q       <= step_d;
      hold_q       <= hold_d;
      step_x_q     <= step_x_d;
      step_y_q     <= step_y_d;
    end
  end

  // Direction next-state: highest-priority freshly pressed key wins, otherwise hold.
  always_comb begin
    new_press = present & ~prev_q;
`ifdef NO_REVERSE_EN
    cand = new_press & ~reverse_mask(dir_q);
`else
    cand = new_press;
`endif
    dir_d = dir_q;
    if (cand[P_UP])         dir_d = UP;
    else if (cand[P_DOWN])  dir_d = DOWN;
    else if (cand[P_LEFT])  dir_d = LEFT;
    else if (cand[P_RIGHT]) dir_d = RIGHT;
  end

  // Pause toggle and ramp; the ramp is frozen whenever this frame ends up paused.
  always_comb begin
    prev_d       = present;
    prev_space_d = space_present;
    paused_d     = paused_q ^ (space_present & ~prev_space_q);
    step_d       = step_q;
    hold_d       = hold_q;
    if (!paused_d) begin
      if (dir_d != dir_q) begin
        step_d = 10'd1;
        hold_d = '0;
      end else if (dir_present(dir_d, present)) begin
        if (hold_q == RAMP_FRAMES - 8'd1) begin
          hold_d = '0;
          if (step_q < MAX_STEP) step_d = step_q + 10'd1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end else begin
        step_d = 10'd1;
        hold_d = '0;
      end
    end
  end

  always_comb begin
    neg_step = ~step_d + 10'd1;
    step_x_d = '0;
    step_y_d = '0;
    if (!paused_d) begin
      case (dir_d)
        UP:      step_y_d = neg_step;
        DOWN:    step_y_d = step_d;
        LEFT:    step_x_d = neg_step;
        RIGHT:   step_x_d = step_d;
        default: begin
          step_x_d = '0;
          step_y_d = '0;
        end
      endcase
    end
  end

  assign step_x = step_x_q;
  assign step_y = step_y_q;
  assign dir    = dir_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_ball_motion_sched.sv
// Scoreboard bench for ball_motion_sched: directed scenarios plus randomized key traffic.
module tb_ball_motion_sched;

  localparam int MAXS = 4;
  localparam int RAMP = 30;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode0 = '0, keycode1 = '0, keycode2 = '0, keycode3 = '0;
  logic [9:0] step_x, step_y;
  logic [2:0] dir;
  logic       paused;

  ball_motion_sched #(.MAX_STEP(10'd4), .RAMP_FRAMES(8'd30)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode0  (keycode0),
    .keycode1  (keycode1),
    .keycode2  (keycode2),
    .keycode3  (keycode3),
    .step_x    (step_x),
    .step_y    (step_y),
    .dir       (dir),
    .paused    (paused)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [2:0] d;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   frame_no = 0;

  // Reference model state; key index 0=UP 1=DOWN 2=LEFT 3=RIGHT, dir code = index+1, 0 = idle.
  logic [7:0] kc [4];
  int   m_dir, m_step, m_hold;
  bit   m_paused, m_prev_sp;
  bit   m_prev [4];

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s frame %0d: got %0d (0x%0h) expected %0d (0x%0h)", name, frame_no, got, got, want, want);
    end
  endtask

  function automatic void model_frame(input logic [7:0] k0, k1, k2, k3, input bit rst, output exp_t e);
    bit pres [4];
    bit sp;
    bit found;
    int nd, sx, sy;
    logic [7:0] slot [4];
    slot[0] = k0; slot[1] = k1; slot[2] = k2; slot[3] = k3;
    if (rst) begin
      m_dir = 0; m_step = 1; m_hold = 0; m_paused = 0; m_prev_sp = 0;
      for (int j = 0; j < 4; j++) m_prev[j] = 0;
      e.d = 3'd0; e.sx = '0; e.sy = '0; e.p = 1'b0;
      return;
    end
    sp = 0;
    for (int j = 0; j < 4; j++) begin
      pres[j] = 0;
      for (int s = 0; s < 4; s++) if (slot[s] == kc[j]) pres[j] = 1;
    end
    for (int s = 0; s < 4; s++) if (slot[s] == 8'h2C) sp = 1;
    nd = m_dir;
    found = 0;
    for (int j = 0; j < 4; j++) begin
      bit blocked;
      blocked = 0;
`ifdef NO_REVERSE_EN
      if (m_dir != 0 && j == ((m_dir - 1) ^ 1)) blocked = 1;
`endif
      if (!found && pres[j] && !m_prev[j] && !blocked) begin
        nd = j + 1;
        found = 1;
      end
    end
    if (sp && !m_prev_sp) m_paused = !m_paused;
    if (!m_paused) begin
      if (nd != m_dir) begin
        m_step = 1; m_hold = 0;
      end else if (nd != 0 && pres[nd-1]) begin
        if (m_hold == RAMP - 1) begin
          m_hold = 0;
          if (m_step < MAXS) m_step++;
        end else m_hold++;
      end else begin
        m_step = 1; m_hold = 0;
      end
    end
    m_dir = nd;
    for (int j = 0; j < 4; j++) m_prev[j] = pres[j];
    m_prev_sp = sp;
    sx = 0; sy = 0;
    if (!m_paused) begin
      case (m_dir)
        1: sy = -m_step;
        2: sy = m_step;
        3: sx = -m_step;
        4: sx = m_step;
        default: ;
      endcase
    end
    e.d = m_dir[2:0]; e.sx = sx[9:0]; e.sy = sy[9:0]; e.p = m_paused;
  endfunction

  task automatic frame(input logic [7:0] k0, k1, k2, k3, input bit rst);
    exp_t e;
    @(negedge frame_clk);
    keycode0 = k0; keycode1 = k1; keycode2 = k2; keycode3 = k3;
    Reset = rst;
    model_frame(k0, k1, k2, k3, rst, e);
    exp_q.push_back(e);
    @(posedge frame_clk);
    #1;
  endtask

  task automatic keys(input logic [7:0] k0, input logic [7:0] k1, input int n);
    for (int i = 0; i < n; i++) frame(k0, k1, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return kc[r];
    if (r == 4) return 8'h2C;
    if (r == 5) return 8'($urandom_range(0, 255));
    return 8'h00;
  endfunction

  // Monitor: every frame produces one output set, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        frame_no++;
        check("dir", int'(dir), int'(e.d));
        check("step_x", int'(step_x), int'(e.sx));
        check("step_y", int'(step_y), int'(e.sy));
        check("paused", int'(paused), int'(e.p));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r0, r1, r2, r3;
    int len;
    kc[0] = 8'h1A; kc[1] = 8'h16; kc[2] = 8'h04; kc[3] = 8'h07;

    // Reset and idle
    do_reset(); do_reset();
    keys(8'h00, 8'h00, 5);
    check("idle_dir", int'(dir), 0);
    check("idle_step_x", int'(step_x), 0);
    check("idle_paused", int'(paused), 0);

    // Tap RIGHT, direction persists after release
    keys(8'h07, 8'h00, 1);
    keys(8'h00, 8'h00, 3);
    check("tap_right_dir", int'(dir), 4);
    check("tap_right_step_x", int'(step_x), 1);

    // Hold UP ramp and saturation
    do_reset();
    keys(8'h1A, 8'h00, 30);
    check("ramp_f30", int'(step_y), 'h3FF);
    keys(8'h1A, 8'h00, 1);
    check("ramp_f31", int'(step_y), 'h3FE);
    keys(8'h1A, 8'h00, 100);
    check("ramp_sat", int'(step_y), 'h3FC);
    keys(8'h00, 8'h00, 1);
    check("ramp_release", int'(step_y), 'h3FF);

    // Priority between new presses
    do_reset();
    keys(8'h04, 8'h00, 2);
    keys(8'h04, 8'h16, 1);
    check("newest_down_dir", int'(dir), 2);
    check("newest_down_y", int'(step_y), 1);
    keys(8'h00, 8'h00, 1);
    keys(8'h1A, 8'h16, 1);
    check("ws_same_frame", int'(dir), 1);

    // Pause toggle
    do_reset();
    keys(8'h2C, 8'h00, 3);
    check("pause_on", int'(paused), 1);
    check("pause_zero_x", int'(step_x), 0);
    keys(8'h00, 8'h00, 1);
    keys(8'h07, 8'h00, 1);
    check("pause_dir_update", int'(dir), 4);
    check("pause_still_zero", int'(step_x), 0);
    keys(8'h2C, 8'h00, 1);
    check("pause_off", int'(paused), 0);
    check("pause_off_x", int'(step_x), 1);

    // Reversal
    do_reset();
    keys(8'h07, 8'h00, 1);
    keys(8'h00, 8'h00, 1);
    keys(8'h04, 8'h00, 1);
`ifdef NO_REVERSE_EN
    check("rev_blocked", int'(dir), 4);
    keys(8'h00, 8'h00, 1);
    keys(8'h04, 8'h1A, 1);
    check("rev_next_prio", int'(dir), 1);
`else
    check("rev_allowed", int'(dir), 3);
    check("rev_step_x", int'(step_x), 'h3FF);
`endif

    // Reset mid-ramp and mid-pause
    keys(8'h04, 8'h00, 40);
    keys(8'h2C, 8'h04, 2);
    do_reset();
    check("midreset_dir", int'(dir), 0);
    check("midreset_paused", int'(paused), 0);

    // Randomized traffic: hold each random key combination for a random run length
    for (int seg = 0; seg < 60; seg++) begin
      r0 = rand_key(); r1 = rand_key(); r2 = rand_key(); r3 = rand_key();
      len = $urandom_range(1, 45);
      if ($urandom_range(0, 29) == 0) do_reset();
      for (int i = 0; i < len; i++) frame(r0, r1, r2, r3, 1'b0);
    end

    repeat (3) @(posedge frame_clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
